// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry registered pipeline stage (MAIN + SKID) with
//               flush, fully registered handshake outputs and saturating
//               stall/bubble performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int WIDTH         = 32,
    parameter int CNT_W         = 16,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [1:0]       c_st_empty = 2'd0;
    localparam logic [1:0]       c_st_one   = 2'd1;
    localparam logic [1:0]       c_st_full  = 2'd2;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [1:0]       w_state_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_main_we;
    logic             w_main_from_skid;
    logic             w_skid_we;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_we        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_we        = 1'b0;
        case (r_state)
            c_st_empty: begin
                if (w_in_xfer) begin
                    w_main_we   = 1'b1;
                    w_state_nxt = c_st_one;
                end
            end
            c_st_one: begin
                case ({w_in_xfer, w_out_xfer})
                    2'b10: begin
                        w_skid_we   = 1'b1;
                        w_state_nxt = c_st_full;
                    end
                    2'b01:   w_state_nxt = c_st_empty;
                    2'b11:   w_main_we   = 1'b1;
                    default: w_state_nxt = c_st_one;
                endcase
            end
            c_st_full: begin
                if (w_out_xfer) begin
                    w_main_we        = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = c_st_one;
                end
            end
            default: w_state_nxt = c_st_empty;
        endcase
        // Flush overrides any transfer; write enables are ignored below.
        if (flush) begin
            w_state_nxt = c_st_empty;
        end
    end

    // Handshake flags are registered from the next state so no input
    // reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_empty;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != c_st_full);
            r_out_valid <= (w_state_nxt != c_st_empty);
            if (flush) begin
                if (ZERO_ON_FLUSH) begin
                    r_main <= '0;
                    r_skid <= '0;
                end
            end else begin
                if (w_main_we) begin
                    r_main <= w_main_from_skid ? r_skid : in_data;
                end
                if (w_skid_we) begin
                    r_skid <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_out_valid && !out_ready && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (out_ready && !r_out_valid && (r_bubble_cnt != c_cnt_max)) begin
                r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_main;
    assign occupancy  = r_state;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg (queue reference model,
//               directed vector table and randomized traffic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [31:0] out_data,  out_data2;
    logic [1:0]  occupancy, occupancy2;
    logic [15:0] stall_cnt, bubble_cnt;
    logic [3:0]  stall_cnt2, bubble_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an ordered list of held entries plus counters.
    logic [31:0] m_q[$];
    int m_stall, m_bubble, m_stall4, m_bubble4;

    pipe_stage_reg #(.WIDTH(32), .CNT_W(16), .ZERO_ON_FLUSH(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.WIDTH(32), .CNT_W(4), .ZERO_ON_FLUSH(1'b0)) u_dut_small (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    // Drive one cycle, advance the model, clock the DUTs, compare everything.
    task automatic cycle(input logic r, input logic f, input logic v,
                         input logic [31:0] d, input logic o);
        bit pre_valid;
        bit pre_room;
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = o;
        pre_valid = (m_q.size() > 0);
        pre_room  = (m_q.size() < 2);
        if (r) begin
            m_q.delete();
            m_stall = 0; m_bubble = 0; m_stall4 = 0; m_bubble4 = 0;
        end else begin
            if (pre_valid && !o) begin
                m_stall  = sat_inc(m_stall, 65535);
                m_stall4 = sat_inc(m_stall4, 15);
            end
            if (o && !pre_valid) begin
                m_bubble  = sat_inc(m_bubble, 65535);
                m_bubble4 = sat_inc(m_bubble4, 15);
            end
            if (f) begin
                m_q.delete();
            end else begin
                if (pre_valid && o) void'(m_q.pop_front());
                if (v && pre_room) m_q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        chk("occupancy",  64'(occupancy),  64'(m_q.size()));
        chk("out_valid",  64'(out_valid),  64'(m_q.size() > 0));
        chk("in_ready",   64'(in_ready),   64'(m_q.size() < 2));
        if (m_q.size() > 0) chk("out_data", 64'(out_data), 64'(m_q[0]));
        chk("stall_cnt",  64'(stall_cnt),  64'(m_stall));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
        chk("occupancy_small",  64'(occupancy2),  64'(m_q.size()));
        if (m_q.size() > 0) chk("out_data_small", 64'(out_data2), 64'(m_q[0]));
        chk("stall_cnt_small",  64'(stall_cnt2),  64'(m_stall4));
        chk("bubble_cnt_small", 64'(bubble_cnt2), 64'(m_bubble4));
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic [1:0]  occ;
        logic        ov;
        logic        ir;
        logic [31:0] data;
    } vec_t;

    vec_t bp[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_next;
        bp[0] = '{1'b1, 32'h1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h1};
        bp[1] = '{1'b1, 32'h2, 1'b0, 2'd2, 1'b1, 1'b0, 32'h1};
        bp[2] = '{1'b1, 32'h3, 1'b0, 2'd2, 1'b1, 1'b0, 32'h1};
        bp[3] = '{1'b1, 32'h3, 1'b0, 2'd2, 1'b1, 1'b0, 32'h1};
        bp[4] = '{1'b1, 32'h3, 1'b1, 2'd1, 1'b1, 1'b1, 32'h2};
        bp[5] = '{1'b1, 32'h3, 1'b1, 2'd1, 1'b1, 1'b1, 32'h3};
        bp[6] = '{1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b1, 32'h3};

        m_stall = 0; m_bubble = 0; m_stall4 = 0; m_bubble4 = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("reset_out_data", 64'(out_data), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h1);

        // Single pass, latency 1
        cycle(0, 0, 1, 32'hDEADBEEF, 1);
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_data",  64'(out_data),  64'hDEADBEEF);
        cycle(0, 0, 0, 0, 1);
        chk("single_drain_occ", 64'(occupancy), 64'h0);

        // Backpressure vector table
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, bp[i].iv, bp[i].d, bp[i].ordy);
            chk($sformatf("bp%0d_occ", i),  64'(occupancy), 64'(bp[i].occ));
            chk($sformatf("bp%0d_ov", i),   64'(out_valid), 64'(bp[i].ov));
            chk($sformatf("bp%0d_ir", i),   64'(in_ready),  64'(bp[i].ir));
            chk($sformatf("bp%0d_data", i), 64'(out_data),  64'(bp[i].data));
        end
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd3);

        // Streaming: 100 back-to-back entries
        cycle(1, 0, 0, 0, 0);
        exp_next = 32'd1;
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 1, 32'(i + 1), 1);
            chk("stream_valid", 64'(out_valid), 64'h1);
            chk("stream_data",  64'(out_data),  64'(exp_next));
            exp_next++;
        end
        cycle(0, 0, 0, 0, 1);
        chk("stream_drain_occ", 64'(occupancy),  64'h0);
        chk("stream_bubble",    64'(bubble_cnt), 64'd1);
        cycle(0, 0, 0, 0, 0);

        // Flush while FULL with a concurrent offer
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h11, 0);
        cycle(0, 0, 1, 32'h22, 0);
        chk("pre_flush_occ", 64'(occupancy), 64'd2);
        cycle(0, 1, 1, 32'h55, 1);
        chk("flush_occ",       64'(occupancy), 64'h0);
        chk("flush_valid",     64'(out_valid), 64'h0);
        chk("flush_data_zero", 64'(out_data),  64'h0);
        chk("flush_data_kept", 64'(out_data2), 64'h11);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 1);
            chk("flush_no_55", 64'(out_valid), 64'h0);
        end

        // Reset mid-operation while FULL with stall_cnt=7
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'hA1, 0);
        cycle(0, 0, 1, 32'hA2, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);
        chk("mid_occ",   64'(occupancy), 64'd2);
        chk("mid_stall", 64'(stall_cnt), 64'd7);
        cycle(1, 1, 1, 32'hBB, 1);
        chk("mid_rst_occ",   64'(occupancy), 64'h0);
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_ready", 64'(in_ready),  64'h1);
        chk("mid_rst_data",  64'(out_data),  64'h0);
        chk("mid_rst_stall", 64'(stall_cnt), 64'h0);
        cycle(0, 0, 1, 32'hA5, 0);
        chk("post_rst_valid", 64'(out_valid), 64'h1);
        chk("post_rst_data",  64'(out_data),  64'hA5);

        // Counter saturation on the 4-bit instance
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1);
        chk("sat_bubble_small", 64'(bubble_cnt2), 64'd15);
        chk("sat_bubble_wide",  64'(bubble_cnt),  64'd20);
        cycle(0, 0, 0, 0, 1);
        chk("sat_bubble_hold",  64'(bubble_cnt2), 64'd15);

        // Randomized traffic against the model
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom,
                  ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
